// File: rtl/ibex_fetch_responder.sv
// ibex_fetch_responder: instruction-fetch bus responder backed by a word-addressed
// internal store. Requests are granted combinationally (subject to backpressure
// and an outstanding-request limit) and answered in order exactly Latency cycles
// after the grant through a fixed-depth response pipeline.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   instr_req_i/addr_i    fetch request and byte address
//   instr_gnt_o           request accepted this cycle (combinational)
//   instr_rvalid_o        response valid (registered)
//   instr_rdata_o/err_o   response data / error, zero when rvalid is low
//   stall_i               suppress grants
//   load_we_i/addr_i/wdata_i  storage write port (word index)
//   busy_o                at least one request outstanding
//   proto_err_o           sticky initiator protocol violation

module ibex_fetch_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter int unsigned Latency        = 2,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        instr_req_i,
  input  logic [31:0]                 instr_addr_i,
  output logic                        instr_gnt_o,
  output logic                        instr_rvalid_o,
  output logic [31:0]                 instr_rdata_o,
  output logic                        instr_err_o,
  input  logic                        stall_i,
  input  logic                        load_we_i,
  input  logic [$clog2(MemWords)-1:0] load_addr_i,
  input  logic [31:0]                 load_wdata_i,
  output logic                        busy_o,
  output logic                        proto_err_o
);

  localparam int unsigned AddrW = $clog2(MemWords);
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic [31:0]     mem_q [MemWords];
  logic [CntW-1:0] count_q, count_d;
  resp_t           pipe_q [Latency];
  resp_t           pipe_d [Latency];
  resp_t           new_resp;
  logic            pend_q, pend_d;
  logic [31:0]     prev_addr_q, prev_addr_d;
  logic            proto_err_q, proto_err_d;
  logic            gnt;
  logic            room;
  logic            addr_err;
  logic            viol_hold;
  logic            viol_over;

  // Storage: no reset; write lands at the edge so a same-cycle grant reads old data.
  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      mem_q[load_addr_i] <= load_wdata_i;
    end
  end

  // Grant: a slot is free, or the oldest response leaves this very cycle.
  // Gated by reset so no grant is visible while the block is held in reset.
  assign room        = (count_q < CntW'(MaxOutstanding)) | instr_rvalid_o;
  assign gnt         = ~rst_i & instr_req_i & ~stall_i & room;
  assign instr_gnt_o = gnt;

  // Response computed from address and storage as seen in the grant cycle.
  assign addr_err = (instr_addr_i[1:0] != 2'b00) |
                    ({2'b00, instr_addr_i[31:2]} >= 32'(MemWords));

  always_comb begin
    new_resp       = '0;
    new_resp.valid = 1'b1;
    new_resp.err   = addr_err;
    new_resp.data  = addr_err ? 32'h0 : mem_q[instr_addr_i[2 +: AddrW]];
  end

  // Response pipeline: stage 0 loads on grant, last stage drives the outputs.
  // Empty stages carry all-zero so data/err are zero whenever rvalid is low.
  always_comb begin
    for (int unsigned i = 0; i < Latency; i++) begin
      pipe_d[i] = '0;
    end
    pipe_d[0] = gnt ? new_resp : '0;
    for (int unsigned i = 1; i < Latency; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Outstanding counter: grant and response in the same cycle cancel.
  always_comb begin
    count_d = count_q;
    case ({gnt, instr_rvalid_o})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Protocol monitor: an ungranted request must be held with a stable address.
  always_comb begin
    pend_d      = instr_req_i & ~gnt;
    prev_addr_d = instr_addr_i;
    viol_hold   = pend_q & (~instr_req_i | (instr_addr_i != prev_addr_q));
    viol_over   = gnt & (count_q == CntW'(MaxOutstanding)) & ~instr_rvalid_o;
    proto_err_d = proto_err_q | viol_hold | viol_over;
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q     <= '0;
      pend_q      <= 1'b0;
      prev_addr_q <= '0;
      proto_err_q <= 1'b0;
      for (int unsigned i = 0; i < Latency; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      count_q     <= count_d;
      pend_q      <= pend_d;
      prev_addr_q <= prev_addr_d;
      proto_err_q <= proto_err_d;
      for (int unsigned i = 0; i < Latency; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign instr_rvalid_o = pipe_q[Latency-1].valid;
  assign instr_rdata_o  = pipe_q[Latency-1].data;
  assign instr_err_o    = pipe_q[Latency-1].err;
  assign busy_o         = (count_q != '0);
  assign proto_err_o    = proto_err_q;

endmodule

// File: tb/tb_ibex_fetch_responder.sv
// Scoreboard bench for ibex_fetch_responder (MemWords=16, Latency=3, MaxOutstanding=2).
module tb_ibex_fetch_responder;

  localparam int unsigned MW  = 16;
  localparam int unsigned LAT = 3;
  localparam int unsigned MO  = 2;
  localparam int unsigned AW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [31:0]   addr;
  logic          stall;
  logic          we;
  logic [AW-1:0] la;
  logic [31:0]   wd;
  logic          gnt, rvalid, err, busy, perr;
  logic [31:0]   rdata;

  always #5 clk = ~clk;

  ibex_fetch_responder #(.MemWords(MW), .Latency(LAT), .MaxOutstanding(MO)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_req_i    (req),
    .instr_addr_i   (addr),
    .instr_gnt_o    (gnt),
    .instr_rvalid_o (rvalid),
    .instr_rdata_o  (rdata),
    .instr_err_o    (err),
    .stall_i        (stall),
    .load_we_i      (we),
    .load_addr_i    (la),
    .load_wdata_i   (wd),
    .busy_o         (busy),
    .proto_err_o    (perr)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sbq[$];     // expected responses, in grant order
  int          due_q[$];   // model: due cycles of outstanding requests
  logic [31:0] mem_m [MW];
  bit          perr_m = 1'b0;
  bit          pr_pend = 1'b0;
  logic [31:0] pr_addr = '0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: predicts grant, busy, proto flag; pushes expected responses.
  always @(negedge clk) begin : model
    bit          room, gnt_e, e;
    logic [31:0] d;
    exp_t        x;
    if (rst) begin
      chk("gnt_in_reset", gnt, 0);
      chk("busy_in_reset", busy, 0);
      chk("proto_in_reset", perr, 0);
      due_q.delete();
      perr_m  = 1'b0;
      pr_pend = 1'b0;
      pr_addr = '0;
    end else begin
      while (due_q.size() > 0 && due_q[0] < cyc) void'(due_q.pop_front());
      room  = (due_q.size() < int'(MO)) || (due_q[0] == cyc);
      gnt_e = req && !stall && room;
      chk("gnt", gnt, 32'(gnt_e));
      chk("busy", busy, 32'(due_q.size() != 0));
      chk("proto_err", perr, 32'(perr_m));
      if (due_q.size() > 0 && due_q[0] == cyc) void'(due_q.pop_front());
      if (gnt_e) begin
        e = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(MW));
        d = e ? 32'h0 : mem_m[addr[2 +: AW]];
        x.data = d;
        x.err  = e;
        x.due  = cyc + int'(LAT);
        sbq.push_back(x);
        due_q.push_back(cyc + int'(LAT));
      end
      if (pr_pend && (!req || addr != pr_addr)) perr_m = 1'b1;
      pr_pend = req && !gnt_e;
      pr_addr = addr;
      if (we) mem_m[la] = wd;
    end
  end

  // Monitor: pops and compares whenever the DUT presents a response.
  always @(negedge clk) begin : monitor
    exp_t x;
    if (rst) begin
      chk("rvalid_in_reset", rvalid, 0);
      chk("rdata_in_reset", rdata, 0);
      chk("err_in_reset", err, 0);
      sbq.delete();
    end else if (rvalid) begin
      n_tests++;
      if (sbq.size() == 0 || sbq[0].due != cyc) begin
        n_fail++;
        $display("FAIL rvalid_timing: got unexpected rvalid, required none (cycle %0d)", cyc);
      end else begin
        x = sbq.pop_front();
        chk("rdata", rdata, x.data);
        chk("err", err, 32'(x.err));
      end
    end else begin
      chk("rdata_idle", rdata, 0);
      chk("err_idle", err, 0);
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL rvalid_missing: got rvalid=0, required 1 (cycle %0d)", cyc);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic drive(input bit r, input logic [31:0] a, input bit s,
                       input bit w = 1'b0, input logic [AW-1:0] l = '0,
                       input logic [31:0] d = '0);
    @(posedge clk);
    #1;
    req = r; addr = a; stall = s; we = w; la = l; wd = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0, 1'b0);
  endtask

  // Hold a request with stable address until granted (bounded).
  task automatic fetch(input logic [31:0] a);
    bit got = 1'b0;
    drive(1'b1, a, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt) begin
        got = 1'b1;
        break;
      end
      drive(1'b1, a, 1'b0);
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL fetch_grant: got no grant within 20 cycles, required grant (addr %h)", a);
    end
  endtask

  initial begin
    bit          hold;
    bit          r;
    logic [31:0] a;
    rst = 1'b1; req = 1'b0; addr = '0; stall = 1'b0; we = 1'b0; la = '0; wd = '0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;

    // Fill storage.
    for (int i = 0; i < int'(MW); i++) drive(1'b0, 32'h0, 1'b0, 1'b1, AW'(i), $urandom);

    // Basic read.
    drive(1'b0, 32'h0, 1'b0, 1'b1, AW'(4), 32'hDEADBEEF);
    fetch(32'h10);
    idle(5);

    // Outstanding limit with back-to-back requests.
    fetch(32'h0); fetch(32'h4); fetch(32'h8);
    idle(6);

    // Error responses: misaligned and out of range.
    fetch(32'h2);
    fetch(32'(MW) * 4);
    idle(6);

    // Stall with stable held request: no grant, no protocol error.
    drive(1'b1, 32'h14, 1'b1);
    drive(1'b1, 32'h14, 1'b1);
    drive(1'b1, 32'h14, 1'b1);
    fetch(32'h14);
    idle(5);

    // Write/read collision on word 1.
    drive(1'b0, 32'h0, 1'b0, 1'b1, AW'(1), 32'h11);
    drive(1'b1, 32'h4, 1'b0, 1'b1, AW'(1), 32'h22);
    idle(5);
    fetch(32'h4);
    idle(5);

    // Reset mid-flight: no response may follow for the discarded grant.
    fetch(32'h8);
    @(posedge clk); #1 rst = 1'b1; req = 1'b0;
    @(negedge clk);
    chk("busy_after_rst", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(6);

    // Protocol violation: address changed while ungranted; flag is sticky.
    drive(1'b1, 32'h30, 1'b1);
    drive(1'b1, 32'h34, 1'b1);
    idle(4);
    @(negedge clk);
    chk("proto_sticky", perr, 1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;

    // Randomized traffic obeying the hold rule.
    hold = 1'b0;
    r    = 1'b0;
    a    = '0;
    repeat (1500) begin
      if (!hold) begin
        r = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 9))
          0:       a = $urandom;
          1:       a = 32'($urandom_range(0, MW - 1)) * 4 + 32'($urandom_range(1, 3));
          2:       a = 32'(MW + $urandom_range(0, 3)) * 4;
          default: a = 32'($urandom_range(0, MW - 1)) * 4;
        endcase
      end
      drive(r, a, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            AW'($urandom_range(0, MW - 1)), $urandom);
      @(negedge clk);
      hold = r && !gnt;
    end
    idle(int'(LAT) + 3);

    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending responses, required 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_fetch_responder.md
IBEX_FETCH_RESPONDER -- requirements
Module: ibex_fetch_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as follows:
  - clk_i  input  1  clock, all state on rising edge
  - rst_i  input  1  reset, asynchronous, active-high
REQ-002 The block SHALL have these parameters (name, default, meaning):
  - MemWords, 1024, words of internal instruction storage (power of 2, >=4)
  - Latency, 2, cycles from grant to rvalid (1..4)
  - MaxOutstanding, 2, maximum granted-but-unanswered requests (1..4)
REQ-003 The block SHALL have these bus-side ports (name, direction, width, meaning):
  - instr_req_i  input  1  request from fetch initiator
  - instr_addr_i  input  32  byte address of request
  - instr_gnt_o  output  1  request accepted this cycle
  - instr_rvalid_o  output  1  response data valid
  - instr_rdata_o  output  32  response data
  - instr_err_o  output  1  response error
REQ-004 The block SHALL have these control and status ports (name, direction, width, meaning):
  - stall_i  input  1  suppress grants (backpressure injection)
  - load_we_i  input  1  storage write enable
  - load_addr_i  input  $clog2(MemWords)  storage word index
  - load_wdata_i  input  32  storage write data
  - busy_o  output  1  at least one request outstanding
  - proto_err_o  output  1  sticky initiator protocol violation

Function
REQ-005 instr_gnt_o SHALL be combinational: instr_req_i & ~stall_i & ((count_q < MaxOutstanding) | instr_rvalid_o).
REQ-006 count_q SHALL count outstanding requests as follows:
  - +1 on a grant cycle
  - -1 on an instr_rvalid_o cycle
  - unchanged when both occur in the same cycle
  - never exceeds MaxOutstanding
REQ-007 A request granted in cycle t SHALL produce instr_rvalid_o=1 in exactly cycle t+Latency, independent of stall_i and of later grants.
REQ-008 Responses SHALL return in grant order, one per cycle at most; back-to-back grants SHALL produce back-to-back rvalids.
REQ-009 Response data and error SHALL be computed from the address and storage contents sampled in the grant cycle, then carried through a Latency-deep response pipeline.
REQ-010 A granted request SHALL be flagged as an error when instr_addr_i[1:0] != 0 or instr_addr_i[31:2] >= MemWords.
  - On error: instr_err_o=1 and instr_rdata_o=0.
  - Otherwise: instr_err_o=0 and instr_rdata_o=mem[instr_addr_i[2+:$clog2(MemWords)]].
REQ-011 instr_rdata_o and instr_err_o SHALL be 0 in every cycle where instr_rvalid_o=0.
REQ-012 load_we_i SHALL write storage at the clock edge; a grant in the same cycle to the same word SHALL return the old data.
REQ-013 busy_o SHALL equal (count_q != 0).
REQ-014 The protocol monitor SHALL set proto_err_o, sticky until reset, when either violation is seen:
  - instr_req_i was 1 and ungranted in cycle t-1, and in cycle t instr_req_i=0 or instr_addr_i differs from its t-1 value.
  - A grant would exceed MaxOutstanding (internal assertion; unreachable by REQ-005).
REQ-015 Storage contents SHALL NOT be reset.

Reset
REQ-016 While rst_i=1, the block SHALL hold these values:
  - instr_gnt_o=0, instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0
  - busy_o=0, proto_err_o=0
  - count_q=0, response pipeline empty, protocol-monitor history cleared
REQ-017 Reset asserted mid-transaction SHALL discard all in-flight responses; no rvalid SHALL appear after deassertion for pre-reset grants.
REQ-018 The first grant SHALL be possible in the first cycle after rst_i deasserts.

Verification
REQ-019 Basic read, Latency=2: load mem[4]=0xDEADBEEF; req addr 0x10 at cycle t -> gnt at t, rvalid at t+2 with rdata 0xDEADBEEF, err=0, busy_o=1 for t+1..t+2.
REQ-020 Outstanding limit, MaxOutstanding=2, Latency=3: req held high with addrs 0x0,0x4,0x8 -> gnt at t and t+1, no gnt at t+2; gnt at t+3 coincident with first rvalid; rvalids in order at t+3, t+4, t+6.
REQ-021 Error response: req addr 0x2 and addr MemWords*4 -> each rvalid has err=1 and rdata=0; count returns to 0.
REQ-022 Stall and protocol: stall_i=1 for 3 cycles with req held and addr stable -> no gnt and proto_err_o=0; repeat with addr changed while ungranted -> proto_err_o=1 next cycle and stays 1.
REQ-023 Reset mid-flight: grant at t, assert rst_i at t+1 for one cycle -> no rvalid ever for that grant; busy_o=0 immediately.
REQ-024 Write/read collision: mem[1]=0x11, same-cycle load_we_i mem[1]=0x22 with granted read 0x4 -> rdata 0x11; subsequent read returns 0x22.
